// File: rtl/viterbi_acs_sched.sv
// Viterbi ACS scheduler: issues NUM_STATES/ACS_PAR groups per symbol, then manages
// path-metric bank swaps, survivor writes, normalisation and traceback start.
// Optional punctured-code erasure ports are enabled by the VITERBI_PUNCT_EN macro.
module viterbi_acs_sched #(
    parameter int unsigned NUM_STATES = 64,
    parameter int unsigned ACS_PAR    = 16,
    parameter int unsigned ACS_LAT    = 1,
    parameter int unsigned TB_DEPTH   = 32,
    localparam int unsigned NGRP      = NUM_STATES / ACS_PAR,
    localparam int unsigned GW        = (NGRP > 1) ? $clog2(NGRP) : 1,
    localparam int unsigned SW        = $clog2(TB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [1:0]       sym_pair,
    input  logic             sym_last,
    input  logic             norm_req,
    output logic [1:0]       acs_pair,
    output logic             acs_en,
    output logic [GW-1:0]    acs_grp,
    output logic             rd_bank,
    output logic             norm_en,
    output logic             surv_we,
    output logic [SW+GW-1:0] surv_addr,
    output logic             tb_start,
    output logic             busy
`ifdef VITERBI_PUNCT_EN
    ,
    input  logic [1:0]       sym_erase,
    output logic [1:0]       acs_erase
`endif
);

    localparam int unsigned CW = (ACS_LAT > 1) ? $clog2(ACS_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StSwap} state_e;

    state_e            state_q, state_d;
    logic [GW-1:0]     grp_q, grp_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     sym_idx_q, sym_idx_d;
    logic [1:0]        pair_q, pair_d;
    logic              last_q, last_d;
    logic              rd_bank_q, rd_bank_d;
    logic              norm_pend_q, norm_pend_d;
    logic              norm_en_q, norm_en_d;
    logic              tb_start_q, tb_start_d;
    logic              acs_en_q, acs_en_d;
    logic              sym_ready_q, sym_ready_d;
    logic              busy_q, busy_d;
    logic [ACS_LAT-1:0] we_pipe_q, we_pipe_d;
    logic [GW-1:0]     grp_pipe_q [ACS_LAT];
    logic [GW-1:0]     grp_pipe_d [ACS_LAT];
    logic              accept;
`ifdef VITERBI_PUNCT_EN
    logic [1:0]        erase_q, erase_d;
`endif

    assign accept = sym_ready_q & sym_valid;

    always_comb begin
        state_d     = state_q;
        grp_d       = grp_q;
        cnt_d       = cnt_q;
        sym_idx_d   = sym_idx_q;
        pair_d      = pair_q;
        last_d      = last_q;
        rd_bank_d   = rd_bank_q;
        norm_pend_d = norm_pend_q;
        norm_en_d   = norm_en_q;
        tb_start_d  = 1'b0;
`ifdef VITERBI_PUNCT_EN
        erase_d     = erase_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    pair_d  = sym_pair;
                    last_d  = sym_last;
                    grp_d   = '0;
                    state_d = StIssue;
`ifdef VITERBI_PUNCT_EN
                    erase_d = sym_erase;
`endif
                end
            end
            StIssue: begin
                if (grp_q == GW'(NGRP - 1)) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    grp_d = grp_q + GW'(1);
                end
            end
            StDrain: begin
                if (cnt_q == CW'(ACS_LAT - 1)) begin
                    tb_start_d = last_q;
                    state_d    = StSwap;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StSwap: begin
                norm_en_d   = norm_pend_q;
                norm_pend_d = 1'b0;
                // Frame end restarts the trellis from a known bank and symbol slot.
                if (last_q) begin
                    sym_idx_d = '0;
                    rd_bank_d = 1'b0;
                end else begin
                    sym_idx_d = sym_idx_q + SW'(1);
                    rd_bank_d = ~rd_bank_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if ((state_q == StIssue || state_q == StDrain) && norm_req) begin
            norm_pend_d = 1'b1;
        end

        acs_en_d    = (state_d == StIssue);
        sym_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);

        // Survivor strobe and group track the ACS result latency.
        we_pipe_d[0]  = acs_en_q;
        grp_pipe_d[0] = grp_q;
        for (int i = 1; i < ACS_LAT; i++) begin
            we_pipe_d[i]  = we_pipe_q[i-1];
            grp_pipe_d[i] = grp_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grp_q       <= '0;
            cnt_q       <= '0;
            sym_idx_q   <= '0;
            pair_q      <= '0;
            last_q      <= 1'b0;
            rd_bank_q   <= 1'b0;
            norm_pend_q <= 1'b0;
            norm_en_q   <= 1'b0;
            tb_start_q  <= 1'b0;
            acs_en_q    <= 1'b0;
            sym_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            we_pipe_q   <= '0;
            for (int i = 0; i < ACS_LAT; i++) begin
                grp_pipe_q[i] <= '0;
            end
`ifdef VITERBI_PUNCT_EN
            erase_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            cnt_q       <= cnt_d;
            sym_idx_q   <= sym_idx_d;
            pair_q      <= pair_d;
            last_q      <= last_d;
            rd_bank_q   <= rd_bank_d;
            norm_pend_q <= norm_pend_d;
            norm_en_q   <= norm_en_d;
            tb_start_q  <= tb_start_d;
            acs_en_q    <= acs_en_d;
            sym_ready_q <= sym_ready_d;
            busy_q      <= busy_d;
            we_pipe_q   <= we_pipe_d;
            for (int i = 0; i < ACS_LAT; i++) begin
                grp_pipe_q[i] <= grp_pipe_d[i];
            end
`ifdef VITERBI_PUNCT_EN
            erase_q     <= erase_d;
`endif
        end
    end

    assign sym_ready = sym_ready_q;
    assign acs_pair  = pair_q;
    assign acs_en    = acs_en_q;
    assign acs_grp   = grp_q;
    assign rd_bank   = rd_bank_q;
    assign norm_en   = norm_en_q;
    assign surv_we   = we_pipe_q[ACS_LAT-1];
    assign surv_addr = {sym_idx_q, grp_pipe_q[ACS_LAT-1]};
    assign tb_start  = tb_start_q;
    assign busy      = busy_q;
`ifdef VITERBI_PUNCT_EN
    assign acs_erase = erase_q;
`endif

endmodule

// File: tb/tb_viterbi_acs_sched.sv
// Directed bench for viterbi_acs_sched with a survivor-write scoreboard.
// Erasure checks are included when VITERBI_PUNCT_EN is defined.
module tb_viterbi_acs_sched;

    localparam int NGRP = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sym_valid;
    logic       sym_ready;
    logic [1:0] sym_pair;
    logic       sym_last;
    logic       norm_req;
    logic [1:0] acs_pair;
    logic       acs_en;
    logic [1:0] acs_grp;
    logic       rd_bank;
    logic       norm_en;
    logic       surv_we;
    logic [6:0] surv_addr;
    logic       tb_start;
    logic       busy;
`ifdef VITERBI_PUNCT_EN
    logic [1:0] sym_erase;
    logic [1:0] acs_erase;
`endif

    int checks   = 0;
    int failures = 0;

    logic [6:0] exp_q [$];
    logic [6:0] mon_exp;
    logic [4:0] exp_idx;
    logic       exp_bank;

    always #5 clk = ~clk;

    viterbi_acs_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_pair  (sym_pair),
        .sym_last  (sym_last),
        .norm_req  (norm_req),
        .acs_pair  (acs_pair),
        .acs_en    (acs_en),
        .acs_grp   (acs_grp),
        .rd_bank   (rd_bank),
        .norm_en   (norm_en),
        .surv_we   (surv_we),
        .surv_addr (surv_addr),
        .tb_start  (tb_start),
        .busy      (busy)
`ifdef VITERBI_PUNCT_EN
        ,
        .sym_erase (sym_erase),
        .acs_erase (acs_erase)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Survivor-write scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && surv_we === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL surv_extra: observed addr=%0h expected=no write", surv_addr);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                chk("surv_addr", 32'(surv_addr), 32'(mon_exp));
            end
        end
    end

    task automatic run_symbol(input logic [1:0] pair, input logic last, input logic [1:0] erase,
                              input logic exp_norm, input bit norm_mid, input bit norm_idle,
                              input bit noise);
        int waited = 0;
        while (sym_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        chk("ready_before_accept", 32'(sym_ready), 32'(1));
        sym_valid = 1'b1;
        sym_pair  = pair;
        sym_last  = last;
        norm_req  = norm_idle;
`ifdef VITERBI_PUNCT_EN
        sym_erase = erase;
`endif
        for (int g = 0; g < NGRP; g++) exp_q.push_back({exp_idx, 2'(g)});
        step();
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        norm_req  = 1'b0;
        sym_pair  = ~pair;
`ifdef VITERBI_PUNCT_EN
        sym_erase = ~erase;
`endif
        for (int g = 0; g < NGRP; g++) begin
            chk("issue_acs_en", 32'(acs_en), 32'(1));
            chk("issue_acs_grp", 32'(acs_grp), 32'(g));
            chk("issue_acs_pair", 32'(acs_pair), 32'(pair));
            chk("issue_sym_ready", 32'(sym_ready), 32'(0));
            chk("issue_busy", 32'(busy), 32'(1));
            chk("issue_norm_en", 32'(norm_en), 32'(exp_norm));
            chk("issue_tb_start", 32'(tb_start), 32'(0));
            chk("issue_rd_bank", 32'(rd_bank), 32'(exp_bank));
`ifdef VITERBI_PUNCT_EN
            chk("issue_acs_erase", 32'(acs_erase), 32'(erase));
`endif
            if (noise) begin
                sym_valid = ~sym_valid;
                sym_pair  = 2'($urandom_range(0, 3));
                sym_last  = 1'b1;
            end
            norm_req = norm_mid && (g == 2);
            step();
        end
        norm_req = 1'b0;
        chk("drain_acs_en", 32'(acs_en), 32'(0));
        chk("drain_busy", 32'(busy), 32'(1));
        chk("drain_norm_en", 32'(norm_en), 32'(exp_norm));
        chk("drain_tb_start", 32'(tb_start), 32'(0));
        chk("drain_acs_pair", 32'(acs_pair), 32'(pair));
        step();
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        chk("swap_tb_start", 32'(tb_start), 32'(last));
        chk("swap_busy", 32'(busy), 32'(1));
        chk("swap_sym_ready", 32'(sym_ready), 32'(0));
        chk("swap_rd_bank", 32'(rd_bank), 32'(exp_bank));
        step();
        if (last) begin
            exp_idx  = '0;
            exp_bank = 1'b0;
        end else begin
            exp_idx  = exp_idx + 5'd1;
            exp_bank = ~exp_bank;
        end
        chk("idle_sym_ready", 32'(sym_ready), 32'(1));
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_tb_start", 32'(tb_start), 32'(0));
        chk("idle_rd_bank", 32'(rd_bank), 32'(exp_bank));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        sym_valid = 1'b0;
        sym_pair  = 2'b00;
        sym_last  = 1'b0;
        norm_req  = 1'b0;
`ifdef VITERBI_PUNCT_EN
        sym_erase = 2'b00;
`endif
        exp_idx   = '0;
        exp_bank  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sym_ready", 32'(sym_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_acs_en", 32'(acs_en), 32'(0));
        chk("rst_rd_bank", 32'(rd_bank), 32'(0));
        chk("rst_surv_we", 32'(surv_we), 32'(0));
        chk("rst_surv_addr", 32'(surv_addr), 32'(0));
        chk("rst_tb_start", 32'(tb_start), 32'(0));
        chk("rst_norm_en", 32'(norm_en), 32'(0));
        chk("rst_acs_pair", 32'(acs_pair), 32'(0));
`ifdef VITERBI_PUNCT_EN
        chk("rst_acs_erase", 32'(acs_erase), 32'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single symbol, then normalisation sequencing.
        run_symbol(2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        run_symbol(2'b01, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        run_symbol(2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        run_symbol(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        // Input activity while busy must be ignored.
        run_symbol(2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("noise_no_accept_busy", 32'(busy), 32'(0));

        // Asynchronous reset in DRAIN.
        sym_valid = 1'b1;
        sym_pair  = 2'b11;
        for (int g = 0; g < NGRP - 1; g++) exp_q.push_back({exp_idx, 2'(g)});
        step();
        sym_valid = 1'b0;
        repeat (NGRP) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sym_ready", 32'(sym_ready), 32'(1));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_acs_en", 32'(acs_en), 32'(0));
        chk("mid_rst_surv_we", 32'(surv_we), 32'(0));
        chk("mid_rst_surv_addr", 32'(surv_addr), 32'(0));
        chk("mid_rst_rd_bank", 32'(rd_bank), 32'(0));
        chk("mid_rst_acs_pair", 32'(acs_pair), 32'(0));
        chk("mid_rst_norm_en", 32'(norm_en), 32'(0));
        chk("mid_rst_pending", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
        exp_idx  = '0;
        exp_bank = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 33 back-to-back symbols: symbol index wraps, frame end on the 33rd.
        for (int s = 0; s < 33; s++) begin
            run_symbol(2'(s), (s == 32), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("frame_end_rd_bank", 32'(rd_bank), 32'(0));

        // Next frame starts at index 0; erasure capture when enabled.
        run_symbol(2'b11, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (5) step();
        chk("end_busy", 32'(busy), 32'(0));
        chk("end_tb_start", 32'(tb_start), 32'(0));
        chk("surv_pending", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/viterbi_acs_sched.md
Name: viterbi_acs_sched

Overview:
- Sequences received symbol pairs through a time-multiplexed bank of ACS_PAR BMC/ACS units covering all NUM_STATES trellis states: NUM_STATES/ACS_PAR groups per symbol.
- Owns the ping-pong select of the path-metric RAM, survivor-memory write addressing, metric normalisation and frame-end traceback kick.
- Sits between the symbol input stream and the BMC/ACS array / survivor memory.

Parameters:
- NUM_STATES, 64, trellis states; power of 2.
- ACS_PAR, 16, parallel ACS units; power of 2, at most NUM_STATES.
- ACS_LAT, 1, cycles from acs_en to ACS result valid; at least 1.
- TB_DEPTH, 32, survivor memory depth in symbols; power of 2.

Derived constants:
- NGRP = NUM_STATES/ACS_PAR.
- GW = max(1, clog2(NGRP)).
- SW = clog2(TB_DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sym_valid  in  1  input symbol valid.
- sym_ready  out  1  scheduler can accept a symbol.
- sym_pair  in  2  received hard-decision pair.
- sym_last  in  1  last symbol of frame, qualified by sym_valid.
- norm_req  in  1  any ACS output metric crossed the normalisation threshold.
- acs_pair  out  2  registered pair driven to all BMC units.
- acs_en  out  1  ACS group issue strobe.
- acs_grp  out  GW  state group being issued.
- rd_bank  out  1  path-metric bank read; write bank = ~rd_bank.
- norm_en  out  1  ACS units subtract the normalisation constant this pass.
- surv_we  out  1  survivor write strobe.
- surv_addr  out  SW+GW  {symbol index, group}.
- tb_start  out  1  one-cycle traceback start pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; sym_ready=1; all other outputs 0; sym_idx=0; rd_bank=0; norm_pend=0; delay pipes cleared. A reset mid-pass abandons the symbol with no write.
- IDLE:
  - sym_ready=1.
  - On sym_valid & sym_ready: capture sym_pair into acs_pair, capture sym_last into last_q, set grp=0, go to ISSUE.
- ISSUE:
  - sym_ready=0, acs_en=1, acs_grp=grp; grp increments each cycle.
  - When grp==NGRP-1, go to DRAIN next cycle.
  - acs_pair is held stable for the whole pass.
- DRAIN: wait exactly ACS_LAT cycles (counter), then go to SWAP.
- SWAP, one cycle:
  - rd_bank toggles.
  - sym_idx increments, wrapping TB_DEPTH-1 to 0.
  - norm_en <= norm_pend, then norm_pend <= 0.
  - If last_q: tb_start=1 this cycle, sym_idx <= 0 (overrides the increment), rd_bank <= 0.
  - Go to IDLE.
- Survivor writes:
  - surv_we is acs_en delayed ACS_LAT cycles.
  - surv_addr = {sym_idx, grp delayed ACS_LAT}.
  - All NGRP writes complete before SWAP.
- Normalisation:
  - norm_req sampled every cycle in ISSUE and DRAIN; any high sets sticky norm_pend.
  - norm_en stays constant across the whole following pass.
  - norm_req outside ISSUE/DRAIN is ignored.
- Throughput: one symbol per NGRP+ACS_LAT+2 cycles. Defaults: 4 ISSUE + 1 DRAIN + 1 SWAP + 1 IDLE = 7 cycles.
- Handshake: sym_pair and sym_last are not sampled unless sym_ready=1. A sym_valid held high while busy is accepted in the first IDLE cycle.
- NGRP==1: ISSUE lasts one cycle; acs_grp is a constant 0.
- tb_start and the next symbol's acceptance never coincide; IDLE always follows SWAP.

Optional Feature:
- Macro: VITERBI_PUNCT_EN.
- Defined:
  - Adds port sym_erase (in, 2) and port acs_erase (out, 2).
  - acs_erase is captured together with sym_pair and held for the pass.
  - A set bit tells the BMC to treat that bit distance as 0 (punctured code).
  - Reset value of acs_erase is 0.
- Undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset release, single symbol pair=2'b10 last=0 → acs_en high 4 cycles with acs_grp 0,1,2,3; surv_addr 0..3 one cycle later; rd_bank 0→1; sym_ready returns 7 cycles after acceptance.
- 33 back-to-back symbols, last on 33rd → surv_addr symbol field wraps 31→0 at symbol 32; tb_start single pulse in the 33rd SWAP; rd_bank=0 and sym_idx=0 afterwards.
- norm_req pulse during group 2 of symbol k → norm_en=1 for all of symbol k+1 and 0 for symbol k+2; norm_req in IDLE → no effect.
- sym_valid toggled and sym_pair changed while busy → acs_pair unchanged during the pass; no extra symbol accepted.
- rst_n asserted in DRAIN → all outputs 0 and sym_ready=1 immediately (asynchronously); after release the next symbol starts at surv_addr 0, rd_bank 0.
- VITERBI_PUNCT_EN build, sym_erase=2'b01 with pair 2'b11 → acs_erase=2'b01 held through ISSUE; reset value 0.
